pc_fetch_unit: RTL and testbench

//  Program-counter and instruction-fetch stage of the RISC core. Holds the PC,

---
 rtl/pc_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: imem req/valid fetch, decode valid/ready delivery.
// Optional HALT support is compiled in with `define FETCH_HALT_EN.
module pc_fetch_unit #(
  parameter int unsigned     PC_W     = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef FETCH_HALT_EN
  ,
  parameter logic [5:0]      HALT_OPCODE = 6'b111111
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_valid,
  input  logic            branch_control,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] link_pc,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3
`ifdef FETCH_HALT_EN
    ,
    ST_HALT = 3'd4
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic [PC_W-1:0] link_pc_q, link_pc_d;
  logic            halted_q, halted_d;
  logic            redirect_pending_q, redirect_pending_d;
  logic            redirect_c;
  logic            accept_c;

  assign redirect_c = branch_valid & branch_control;
  assign accept_c   = instr_valid_q & instr_ready;

  // Next-state and datapath update; redirect outranks every other event.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    imem_req_d         = imem_req_q;
    imem_addr_d        = imem_addr_q;
    instr_d            = instr_q;
    instr_valid_d      = instr_valid_q;
    instr_pc_d         = instr_pc_q;
    link_pc_d          = link_pc_q;
    halted_d           = halted_q;
    redirect_pending_d = redirect_pending_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (redirect_c) begin
          pc_d = branch_target;
        end else if (!stall) begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_valid) begin
          imem_req_d = 1'b0;
          // A response coinciding with a redirect belongs to the stale path: drop it.
          if (redirect_c || redirect_pending_q) begin
            redirect_pending_d = 1'b0;
            state_d            = ST_REQ;
            if (redirect_c) begin
              pc_d = branch_target;
            end
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            link_pc_d     = pc_q + PC_ONE;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else if (redirect_c) begin
          pc_d               = branch_target;
          redirect_pending_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect_c) begin
          instr_valid_d = 1'b0;
          pc_d          = branch_target;
          state_d       = ST_REQ;
        end else if (accept_c) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_q + PC_ONE;
          state_d       = ST_REQ;
`ifdef FETCH_HALT_EN
          if (instr_q[31:26] == HALT_OPCODE) begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
`endif
        end
      end

`ifdef FETCH_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      pc_q               <= RESET_PC;
      imem_req_q         <= 1'b0;
      imem_addr_q        <= RESET_PC;
      instr_q            <= '0;
      instr_valid_q      <= 1'b0;
      instr_pc_q         <= RESET_PC;
      link_pc_q          <= RESET_PC + PC_ONE;
      halted_q           <= 1'b0;
      redirect_pending_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      imem_req_q         <= imem_req_d;
      imem_addr_q        <= imem_addr_d;
      instr_q            <= instr_d;
      instr_valid_q      <= instr_valid_d;
      instr_pc_q         <= instr_pc_d;
      link_pc_q          <= link_pc_d;
      halted_q           <= halted_d;
      redirect_pending_q <= redirect_pending_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign link_pc     = link_pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a PC-sequence model.
module tb_pc_fetch_unit;
  localparam int unsigned PC_W = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            branch_valid, branch_control, stall;
  logic [PC_W-1:0] branch_target;
  logic            imem_req, imem_valid;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata, instr;
  logic            instr_valid, instr_ready, halted;
  logic [PC_W-1:0] instr_pc, link_pc;

  int n_checks = 0;
  int n_fail   = 0;

  int  mem_lat   = 0;
  int  halt_addr = -1;
  bit  in_req    = 1'b0;
  bit  served    = 1'b0;
  int  lat_cnt   = 0;
  logic [PC_W-1:0] req_q[$];

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .branch_valid(branch_valid), .branch_control(branch_control), .branch_target(branch_target),
    .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc), .link_pc(link_pc), .halted(halted)
  );

  // Instruction memory contents: low bits encode the address so every word is distinct.
  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    if (halt_addr >= 0 && int'(a) == halt_addr) return 32'hFC00_0000;
    return {6'h05, 15'(a * 11'd13 + 11'd7), a};
  endfunction

  // Advance to the next falling edge, end branch pulses, and run the memory responder.
  task automatic tick();
    @(negedge clk);
    branch_valid   = 1'b0;
    branch_control = 1'b0;
    if (imem_valid) imem_valid = 1'b0;
    if (!imem_req) begin
      in_req = 1'b0;
    end else begin
      if (!in_req) begin
        in_req  = 1'b1;
        served  = 1'b0;
        lat_cnt = mem_lat;
        req_q.push_back(imem_addr);
      end
      if (!served) begin
        if (lat_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(imem_addr);
          served     = 1'b1;
        end else begin
          lat_cnt--;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_control = 1'b0; branch_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    req_q.delete();
  endtask

  task automatic wait_valid(input int max, output bit ok);
    int i = 0;
    ok = instr_valid;
    while (!ok && i < max) begin
      tick();
      ok = instr_valid;
      i++;
    end
  endtask

  task automatic wait_reqs(input int n, input int max, output bit ok);
    int i = 0;
    ok = (req_q.size() >= n);
    while (!ok && i < max) begin
      tick();
      ok = (req_q.size() >= n);
      i++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_control = 1'b0; branch_target = '0;
    imem_valid = 1'b0; imem_rdata = '0; mem_lat = 0;
    tick(); tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req got %0b want 0", imem_req); end
    n_checks++; if (imem_addr !== 11'h000) begin n_fail++; $display("FAIL reset_imem_addr got %0h want 0", imem_addr); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %0h want 0", instr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %0b want 0", instr_valid); end
    n_checks++; if (instr_pc !== 11'h000) begin n_fail++; $display("FAIL reset_instr_pc got %0h want 0", instr_pc); end
    n_checks++; if (link_pc !== 11'h001) begin n_fail++; $display("FAIL reset_link_pc got %0h want 1", link_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0b want 0", halted); end
    rst = 1'b0;
    req_q.delete();
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got %0b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 11'h000) begin
      n_fail++; $display("FAIL first_req got req=%0b addr=%0h want req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset();
    instr_ready = 1'b1; mem_lat = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_timeout got no instr_valid want instr %0d", k); end
      n_checks++; if (instr_pc !== PC_W'(k)) begin n_fail++; $display("FAIL seq_instr_pc got %0h want %0h", instr_pc, k); end
      n_checks++; if (instr !== mem_word(PC_W'(k))) begin n_fail++; $display("FAIL seq_instr got %0h want %0h", instr, mem_word(PC_W'(k))); end
      n_checks++; if (link_pc !== PC_W'(k + 1)) begin n_fail++; $display("FAIL seq_link_pc got %0h want %0h", link_pc, k + 1); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (req_q.size() <= k || req_q[k] !== PC_W'(k)) begin
        n_fail++; $display("FAIL seq_req_addr index %0d got %0h (n=%0d) want %0h", k, (req_q.size() > k) ? req_q[k] : 11'h0, req_q.size(), k); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    instr_ready = 1'b1; mem_lat = 0;
    tick();
    branch_valid = 1'b1; branch_control = 1'b1; branch_target = 11'h7FF;
    wait_valid(20, ok);
    n_checks++; if (!ok || instr_pc !== 11'h7FF) begin n_fail++; $display("FAIL wrap_instr_pc got %0h valid=%0b want 7ff", instr_pc, ok); end
    n_checks++; if (link_pc !== 11'h000) begin n_fail++; $display("FAIL wrap_link_pc got %0h want 0", link_pc); end
    n_checks++; if (instr !== mem_word(11'h7FF)) begin n_fail++; $display("FAIL wrap_instr got %0h want %0h", instr, mem_word(11'h7FF)); end
    tick();
    wait_reqs(2, 20, ok);
    n_checks++; if (!ok || req_q[0] !== 11'h7FF || req_q[1] !== 11'h000) begin
      n_fail++; $display("FAIL wrap_next_addr got n=%0d want addrs 7ff then 0", req_q.size()); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int seen_valid = 0;
    int i = 0;
    do_reset();
    instr_ready = 1'b1; mem_lat = 1;
    wait_reqs(6, 200, ok);
    n_checks++; if (!ok || req_q[5] !== 11'h005 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_setup got n=%0d valid=%0b want 6th request at 5", req_q.size(), instr_valid); end
    branch_valid = 1'b1; branch_control = 1'b1; branch_target = 11'h040;
    while (req_q.size() < 7 && i < 30) begin
      tick();
      if (instr_valid) seen_valid++;
      i++;
    end
    n_checks++; if (seen_valid != 0) begin n_fail++; $display("FAIL rw_discard got %0d valid cycles want 0", seen_valid); end
    n_checks++; if (req_q.size() < 7 || req_q[6] !== 11'h040) begin
      n_fail++; $display("FAIL rw_next_addr got n=%0d want request at 40", req_q.size()); end
    wait_valid(20, ok);
    n_checks++; if (!ok || instr_pc !== 11'h040 || instr !== mem_word(11'h040)) begin
      n_fail++; $display("FAIL rw_deliver got pc=%0h instr=%0h want pc=40 instr=%0h", instr_pc, instr, mem_word(11'h040)); end
    mem_lat = 0;
  endtask

  task automatic test_stall_hold();
    bit ok;
    int n;
    do_reset();
    instr_ready = 1'b0; mem_lat = 0;
    wait_valid(20, ok);
    n_checks++; if (!ok || instr !== mem_word(11'h000)) begin
      n_fail++; $display("FAIL sh_setup got valid=%0b instr=%0h want %0h", ok, instr, mem_word(11'h000)); end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(11'h000) || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL sh_hold cycle %0d got valid=%0b instr=%0h req=%0b want 1/%0h/0", k, instr_valid, instr, imem_req, mem_word(11'h000)); end
    end
    branch_valid = 1'b1; branch_control = 1'b1; branch_target = 11'h010;
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL sh_flush got %0b want 0", instr_valid); end
    tick(); tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL sh_stall_req got %0b want 0", imem_req); end
    n = req_q.size();
    stall = 1'b0;
    wait_reqs(n + 1, 20, ok);
    n_checks++; if (!ok || req_q[n] !== 11'h010) begin n_fail++; $display("FAIL sh_redirect_addr got n=%0d want request at 10", req_q.size()); end
  endtask

  task automatic test_not_taken();
    bit ok;
    int n;
    logic [PC_W-1:0] p;
    do_reset();
    instr_ready = 1'b0; mem_lat = 0;
    wait_valid(20, ok);
    p = instr_pc;
    branch_valid = 1'b1; branch_control = 1'b0; branch_target = 11'h123;
    tick();
    n_checks++; if (!ok || instr_valid !== 1'b1 || instr_pc !== 11'h000) begin
      n_fail++; $display("FAIL nt_no_flush got valid=%0b pc=%0h want 1/0", instr_valid, instr_pc); end
    n = req_q.size();
    instr_ready = 1'b1;
    wait_reqs(n + 1, 20, ok);
    n_checks++; if (!ok || req_q[n] !== 11'h001) begin n_fail++; $display("FAIL nt_sequential got n=%0d want request at 1 (held pc %0h)", req_q.size(), p); end
    instr_ready = 1'b0;
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    bit found = 1'b0;
    int i = 0;
    int activity = 0;
    do_reset();
    halt_addr = 3; instr_ready = 1'b1; mem_lat = 0;
    while (!found && i < 100) begin
      if (instr_valid && instr_pc == 11'h003) found = 1'b1;
      else tick();
      i++;
    end
    n_checks++; if (!found || instr !== 32'hFC00_0000) begin n_fail++; $display("FAIL halt_deliver got found=%0b instr=%0h want fc000000", found, instr); end
    tick();
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter got halted=%0b req=%0b valid=%0b want 1/0/0", halted, imem_req, instr_valid); end
    branch_valid = 1'b1; branch_control = 1'b1; branch_target = 11'h020;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (imem_req || instr_valid || !halted) activity++;
    end
    n_checks++; if (activity != 0) begin n_fail++; $display("FAIL halt_absorb got %0d active cycles want 0", activity); end
    halt_addr = -1;
    do_reset();
    n_checks++; if (halted !== 1'b0 || instr_pc !== 11'h000) begin n_fail++; $display("FAIL halt_reset got halted=%0b pc=%0h want 0/0", halted, instr_pc); end
    tick(); tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 11'h000) begin n_fail++; $display("FAIL halt_restart got req=%0b addr=%0h want 1/0", imem_req, imem_addr); end
  endtask
`endif

  // Randomized traffic: the model tracks only the architectural next-fetch PC.
  task automatic test_random();
    logic [PC_W-1:0] model_pc = '0;
    logic [PC_W-1:0] cur_addr = '0;
    bit prev_stall = 1'b0;
    int nreq = 0;
    int accepted = 0;
    int errs = 0;
    do_reset();
    tick(); tick();
    for (int c = 0; c < 3000; c++) begin
      if (instr_valid) begin
        n_checks++; if (instr_pc !== model_pc) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_instr_pc cycle %0d got %0h want %0h", c, instr_pc, model_pc); end
        n_checks++; if (instr !== mem_word(instr_pc)) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_instr cycle %0d got %0h want %0h", c, instr, mem_word(instr_pc)); end
        n_checks++; if (link_pc !== instr_pc + 11'd1) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_link_pc cycle %0d got %0h want %0h", c, link_pc, instr_pc + 11'd1); end
      end
      if (req_q.size() > nreq) begin
        nreq = req_q.size();
        cur_addr = imem_addr;
        n_checks++; if (req_q[nreq-1] !== model_pc) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_req_addr cycle %0d got %0h want %0h", c, req_q[nreq-1], model_pc); end
        n_checks++; if (prev_stall) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_stall_req cycle %0d got request under stall want none", c); end
      end else if (imem_req) begin
        n_checks++; if (imem_addr !== cur_addr) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_addr_hold cycle %0d got %0h want %0h", c, imem_addr, cur_addr); end
      end
      n_checks++; if (halted !== 1'b0) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_halted cycle %0d got 1 want 0", c); end

      stall       = ($urandom_range(0, 4) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      mem_lat     = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) begin
        branch_valid   = 1'b1;
        branch_control = 1'($urandom_range(0, 1));
        branch_target  = ($urandom_range(0, 3) == 0) ? 11'h7FF : PC_W'($urandom);
      end
      if (branch_valid && branch_control) begin
        model_pc = branch_target;
      end else if (instr_valid && instr_ready) begin
        model_pc = model_pc + 11'd1;
        accepted++;
      end
      prev_stall = stall;
      tick();
    end
    n_checks++; if (accepted < 100) begin n_fail++; $display("FAIL rnd_throughput got %0d accepted want >= 100", accepted); end
    stall = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_wait();
    test_stall_hold();
    test_not_taken();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
